hwpe_stream_tcdm_load_streamer: RTL

- Upstream address generator and downstream stream consumer for the TCDM load FIFO stage.
- On start, issues a strided sequence of word-load requests on a TCDM master port that connects to the FIFO stage's slave side.
- Collects the in-order read responses and presents them as a 32-bit valid/ready HWPE stream, with a last-beat flag and a done pulse.
- Drives the FIFO stage's response-consume strobe (ready) from the output stream's ready.

---
 rtl/hwpe_stream_tcdm_load_streamer_if.sv | 31 +++
 rtl/hwpe_stream_tcdm_load_streamer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_tcdm_load_streamer_if.sv
// Bus bundle for hwpe_stream_tcdm_load_streamer: the TCDM request/response
// side towards the load FIFO stage and the 32-bit HWPE output stream.
// The master modport is the streamer's view; slave is the environment's.
interface hwpe_stream_tcdm_load_streamer_if;
    // TCDM request channel
    logic        tcdm_req_o;
    logic [31:0] tcdm_add_o;
    logic        tcdm_gnt_i;
    // TCDM response channel from the FIFO stage
    logic [31:0] tcdm_r_data_i;
    logic        tcdm_r_valid_i;
    logic        tcdm_r_ready_o;
    // Output stream
    logic [31:0] out_data_o;
    logic [3:0]  out_strb_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;

    modport master (
        output tcdm_req_o, tcdm_add_o, tcdm_r_ready_o,
        output out_data_o, out_strb_o, out_valid_o, out_last_o,
        input  tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i, out_ready_i
    );

    modport slave (
        input  tcdm_req_o, tcdm_add_o, tcdm_r_ready_o,
        input  out_data_o, out_strb_o, out_valid_o, out_last_o,
        output tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i, out_ready_i
    );
endinterface

// File: rtl/hwpe_stream_tcdm_load_streamer.sv
// Strided TCDM load streamer: issues word-load requests from a base address
// with a signed byte stride, turns the in-order responses of the load FIFO
// stage into a valid/ready stream with a last flag, and pulses done.
// Optional: define HWPE_STREAM_LOAD_STREAMER_PERF_EN to add perf_stall_o,
// a saturating count of busy cycles stalled on grant or on stream ready.
module hwpe_stream_tcdm_load_streamer #(
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [31:0]                 base_addr_i,
    input  logic signed [31:0]          stride_i,
    input  logic [LEN_WIDTH-1:0]        length_i,
    output logic                        busy_o,
    output logic                        done_o,
`ifdef HWPE_STREAM_LOAD_STREAMER_PERF_EN
    output logic [31:0]                 perf_stall_o,
`endif
    hwpe_stream_tcdm_load_streamer_if.master bus
);

    localparam int unsigned      OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic signed [31:0]   stride_q, stride_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] issued_cnt_q, issued_cnt_d;
    logic [LEN_WIDTH-1:0] recv_cnt_q, recv_cnt_d;
    logic [OUT_W-1:0]     outstanding_q, outstanding_d;

    logic busy;
    logic req;
    logic grant;
    logic out_valid;
    logic accept;
    logic last_beat;

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    // Requests stop once every word is issued or the FIFO stage is full.
    assign req       = (state_q == RUN) && (issued_cnt_q < len_q) && (outstanding_q < MAX_OUT);
    assign grant     = req & bus.tcdm_gnt_i;
    // Responses are only visible/consumed while a transfer is active.
    assign out_valid = bus.tcdm_r_valid_i & busy;
    assign accept    = out_valid & bus.out_ready_i;
    assign last_beat = (recv_cnt_q == len_q - LEN_WIDTH'(1));

    assign busy_o             = busy;
    assign done_o             = (state_q == DONE);
    assign bus.tcdm_req_o     = req;
    assign bus.tcdm_add_o     = addr_q;
    assign bus.tcdm_r_ready_o = bus.out_ready_i & busy;
    assign bus.out_data_o     = bus.tcdm_r_data_i;
    assign bus.out_strb_o     = 4'hF;
    assign bus.out_valid_o    = out_valid;
    assign bus.out_last_o     = out_valid & last_beat;

    // Next-state: FSM sequencing, address stepping and the three counters.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        stride_d      = stride_q;
        len_d         = len_q;
        issued_cnt_d  = issued_cnt_q;
        recv_cnt_d    = recv_cnt_q;
        outstanding_d = outstanding_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d        = base_addr_i;
                    stride_d      = stride_i;
                    len_d         = length_i;
                    issued_cnt_d  = '0;
                    recv_cnt_d    = '0;
                    outstanding_d = '0;
                    state_d       = (length_i != '0) ? RUN : DONE;
                end
            end
            RUN, DRAIN: begin
                if (grant) begin
                    // Two's-complement add wraps modulo 2^32 for negative strides.
                    addr_d       = addr_q + $unsigned(stride_q);
                    issued_cnt_d = issued_cnt_q + LEN_WIDTH'(1);
                end
                if (accept) begin
                    recv_cnt_d = recv_cnt_q + LEN_WIDTH'(1);
                end
                // A grant and an accept in the same cycle cancel out.
                case ({grant, accept})
                    2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
                    2'b01:   outstanding_d = (outstanding_q != '0) ? outstanding_q - OUT_W'(1)
                                                                   : outstanding_q;
                    default: outstanding_d = outstanding_q;
                endcase
                if (accept && last_beat) begin
                    state_d = DONE;
                end else if (grant && (issued_cnt_q == len_q - LEN_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear aborts any transfer; the FIFO stage is cleared alongside.
        if (clear_i) begin
            state_d       = IDLE;
            addr_d        = '0;
            len_d         = '0;
            issued_cnt_d  = '0;
            recv_cnt_d    = '0;
            outstanding_d = '0;
        end
    end

    // Control state and address register, async active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            issued_cnt_q  <= '0;
            recv_cnt_q    <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            issued_cnt_q  <= issued_cnt_d;
            recv_cnt_q    <= recv_cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Stride is pure configuration data, only meaningful once latched by start.
    always_ff @(posedge clk_i) begin
        stride_q <= stride_d;
    end

`ifdef HWPE_STREAM_LOAD_STREAMER_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign stall        = busy & ((req & ~bus.tcdm_gnt_i) | (out_valid & ~bus.out_ready_i));
    assign perf_stall_o = perf_stall_q;

    // Stall counter restarts on clear and on every accepted start.
    always_comb begin
        perf_stall_d = perf_stall_q;
        if (clear_i || ((state_q == IDLE) && start_i)) begin
            perf_stall_d = '0;
        end else if (stall) begin
            perf_stall_d = sat_inc(perf_stall_q);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
        end
    end
`endif

endmodule
